// File: rtl/mapping_group_ctrl.sv
// ============================================================================
// Module   : mapping_group_ctrl
// Purpose  : Control sequencer for mapping_group_top (ADC capture, bit-slice steps)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mapping_group_ctrl #(
  parameter int DATA_W     = 32,
  parameter int MAX_SLICES = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              mode_cfg_i,
  input  logic [2:0]        num_slices_i,
  input  logic [DATA_W-1:0] zp_i,
  output logic              adc_req_o,
  input  logic              adc_valid_i,
  input  logic [DATA_W-1:0] adc_data_i,
  output logic [DATA_W-1:0] output_o,
  output logic              buf_write_en_1_o,
  output logic              buf_write_en_2_o,
  output logic              buf_read_en_o,
  output logic              shift_counter_en_o,
  output logic              mode_o,
  output logic              accum_buf_write_o,
  output logic              zero_point_en_o,
  output logic [DATA_W-1:0] zero_point_o,
  output logic              load_en_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_ZP   = 4'd1,
    S_REQ1 = 4'd2,
    S_WR1  = 4'd3,
    S_REQ2 = 4'd4,
    S_WR2  = 4'd5,
    S_RD   = 4'd6,
    S_ACC  = 4'd7,
    S_LOAD = 4'd8,
    S_DONE = 4'd9
  } state_e;

  localparam logic [2:0] MAX_N = 3'(MAX_SLICES);

  state_e              state_q;
  logic [2:0]          n_q;
  logic [2:0]          slice_cnt_q;
  logic [DATA_W-1:0]   sample_q;
  logic [DATA_W-1:0]   zp_q;
  logic                mode_q;
  logic [2:0]          n_eff;

  // Zero slices still performs one pass; oversize requests saturate.
  always_comb begin
    n_eff = num_slices_i;
    if (num_slices_i == 3'd0) begin
      n_eff = 3'd1;
    end else if (num_slices_i > MAX_N) begin
      n_eff = MAX_N;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      n_q         <= 3'd1;
      slice_cnt_q <= 3'd0;
      sample_q    <= '0;
      zp_q        <= '0;
      mode_q      <= 1'b0;
    end else if (abort_i) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            mode_q      <= mode_cfg_i;
            n_q         <= n_eff;
            zp_q        <= zp_i;
            slice_cnt_q <= 3'd0;
            state_q     <= S_ZP;
          end
        end
        S_ZP:   state_q <= S_REQ1;
        S_REQ1: begin
          if (adc_valid_i) begin
            sample_q <= adc_data_i;
            state_q  <= S_WR1;
          end
        end
        S_WR1:  state_q <= mode_q ? S_REQ2 : S_RD;
        S_REQ2: begin
          if (adc_valid_i) begin
            sample_q <= adc_data_i;
            state_q  <= S_WR2;
          end
        end
        S_WR2:  state_q <= S_RD;
        S_RD:   state_q <= S_ACC;
        S_ACC: begin
          if (slice_cnt_q == n_q - 3'd1) begin
            state_q <= S_LOAD;
          end else begin
            slice_cnt_q <= slice_cnt_q + 3'd1;
            state_q     <= S_REQ1;
          end
        end
        S_LOAD: state_q <= S_DONE;
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes decode only the state register, so each lasts exactly one state.
  assign adc_req_o          = (state_q == S_REQ1) || (state_q == S_REQ2);
  assign zero_point_en_o    = (state_q == S_ZP);
  assign buf_write_en_1_o   = (state_q == S_WR1);
  assign buf_write_en_2_o   = (state_q == S_WR2);
  assign buf_read_en_o      = (state_q == S_RD);
  assign accum_buf_write_o  = (state_q == S_ACC);
  assign shift_counter_en_o = (state_q == S_ACC);
  assign load_en_o          = (state_q == S_LOAD);
  assign done_o             = (state_q == S_DONE);
  assign busy_o             = (state_q != S_IDLE);
  assign output_o           = sample_q;
  assign zero_point_o       = zp_q;
  assign mode_o             = mode_q;

endmodule

`default_nettype wire

// File: tb/tb_mapping_group_ctrl.sv
// ============================================================================
// Module   : tb_mapping_group_ctrl
// Purpose  : Scoreboard bench for mapping_group_ctrl strobe sequencing
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mapping_group_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        mode_cfg_i = 1'b0;
  logic [2:0]  num_slices_i = 3'd0;
  logic [31:0] zp_i = '0;
  logic        adc_req_o;
  logic        adc_valid_i = 1'b0;
  logic [31:0] adc_data_i = '0;
  logic [31:0] output_o;
  logic        buf_write_en_1_o, buf_write_en_2_o, buf_read_en_o, shift_counter_en_o;
  logic        mode_o, accum_buf_write_o, zero_point_en_o, load_en_o, busy_o, done_o;
  logic [31:0] zero_point_o;

  mapping_group_ctrl #(.DATA_W(32), .MAX_SLICES(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .mode_cfg_i(mode_cfg_i), .num_slices_i(num_slices_i), .zp_i(zp_i),
    .adc_req_o(adc_req_o), .adc_valid_i(adc_valid_i), .adc_data_i(adc_data_i),
    .output_o(output_o), .buf_write_en_1_o(buf_write_en_1_o),
    .buf_write_en_2_o(buf_write_en_2_o), .buf_read_en_o(buf_read_en_o),
    .shift_counter_en_o(shift_counter_en_o), .mode_o(mode_o),
    .accum_buf_write_o(accum_buf_write_o), .zero_point_en_o(zero_point_en_o),
    .zero_point_o(zero_point_o), .load_en_o(load_en_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          cyc;
    logic [7:0]  strb;
    logic [31:0] out;
    logic [31:0] zp;
    logic        mode;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] adc_q[$];
  logic [31:0] samp[8];
  logic [31:0] last_out = '0;
  int          cyc = 0;
  int          stall_n = 0;
  bit          junk_en = 1'b0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Strobe vector: zp, wr1, wr2, rd, acc, shift, load, done
  function automatic logic [7:0] strobes();
    return {zero_point_en_o, buf_write_en_1_o, buf_write_en_2_o, buf_read_en_o,
            accum_buf_write_o, shift_counter_en_o, load_en_o, done_o};
  endfunction

  // ADC model: answers each request after an optional stall, pops one sample per answer.
  always @(negedge clk_i) begin
    if (adc_req_o) begin
      if (stall_n > 0) begin
        adc_valid_i = 1'b0;
        stall_n     = stall_n - 1;
      end else if (adc_q.size() > 0) begin
        adc_valid_i = 1'b1;
        adc_data_i  = adc_q.pop_front();
      end else begin
        adc_valid_i = 1'b0;
      end
    end else if (junk_en) begin
      adc_valid_i = 1'b1;
      adc_data_i  = 32'hDEAD_BEEF;
    end else begin
      adc_valid_i = 1'b0;
    end
  end

  // Monitor: every strobe cycle is matched against the next expected event.
  always @(negedge clk_i) begin
    logic [7:0] s;
    ev_t e;
    s = strobes();
    if (rst_ni && s != 8'h00) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_strobe cyc=%0d strb=%b required none", cyc, s);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.cyc || s != e.strb || output_o != e.out || zero_point_o != e.zp ||
            mode_o != e.mode || busy_o != 1'b1 || adc_req_o != 1'b0) begin
          errors = errors + 1;
          $display("FAIL event got cyc=%0d strb=%b out=%h zp=%h mode=%b busy=%b req=%b required cyc=%0d strb=%b out=%h zp=%h mode=%b busy=1 req=0",
                   cyc, s, output_o, zero_point_o, mode_o, busy_o, adc_req_o,
                   e.cyc, e.strb, e.out, e.zp, e.mode);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  task automatic at_cycle(input int t);
    while (cyc < t) begin
      @(posedge clk_i);
      #1;
    end
    @(negedge clk_i);
  endtask

  function automatic void add(input int t, input int lim, input logic [7:0] s,
                              input logic [31:0] zp, input logic m);
    ev_t e;
    if (t < lim) begin
      e.cyc = t; e.strb = s; e.out = last_out; e.zp = zp; e.mode = m;
      exp_q.push_back(e);
    end
  endfunction

  // Starts an operation and pushes its expected events; events at or after c0+cut are dropped.
  task automatic launch(input logic m, input logic [2:0] n, input logic [31:0] zp,
                        input int stall, input int cut, output int c0);
    int neff, t, k, lim;
    neff = (n == 3'd0) ? 1 : ((n > 3'd4) ? 4 : int'(n));
    adc_q.delete();
    for (int i = 0; i < neff * (m ? 2 : 1); i++) adc_q.push_back(samp[i]);
    stall_n = stall;
    @(posedge clk_i);
    #1;
    mode_cfg_i = m; num_slices_i = n; zp_i = zp; start_i = 1'b1;
    c0  = cyc;
    lim = (cut == 0) ? 32'h4000_0000 : c0 + cut;
    add(c0 + 1, lim, 8'h80, zp, m);
    t = c0 + 2 + stall;
    k = 0;
    for (int s = 0; s < neff; s++) begin
      t++;
      if (t < lim) last_out = samp[k];
      k++;
      add(t, lim, 8'h40, zp, m);
      if (m) begin
        t += 2;
        if (t < lim) last_out = samp[k];
        k++;
        add(t, lim, 8'h20, zp, m);
      end
      t++; add(t, lim, 8'h10, zp, m);
      t++; add(t, lim, 8'h0C, zp, m);
      t++;
    end
    add(t, lim, 8'h02, zp, m);
    add(t + 1, lim, 8'h01, zp, m);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return {30'd0, adc_req_o, busy_o, done_o, zero_point_en_o, buf_write_en_1_o,
            buf_write_en_2_o, buf_read_en_o, shift_counter_en_o, mode_o,
            accum_buf_write_o, load_en_o, (output_o | zero_point_o) != 32'd0};
  endfunction

  initial begin
    int c0;
    logic any_strb;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_outputs", all_outs(), 64'd0);
    chk("reset_data", {output_o, zero_point_o}, 64'd0);
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("idle_busy", {63'd0, busy_o}, 64'd0);

    // Row-by-row, four slices
    for (int i = 0; i < 8; i++) samp[i] = 32'hFEFE_FEFE;
    launch(1'b0, 3'd4, 32'd10, 0, 0, c0);
    at_cycle(c0 + 1);  chk("busy_c1", {63'd0, busy_o}, 64'd1);
    at_cycle(c0 + 19); chk("busy_c19", {63'd0, busy_o}, 64'd1);
    at_cycle(c0 + 20); chk("busy_c20", {63'd0, busy_o}, 64'd0);
    at_cycle(c0 + 22); chk("row4_events_left", 64'(exp_q.size()), 64'd0);

    // Parallel, two slices
    samp[0] = 32'h8080_8080; samp[1] = 32'hF8F8_F8F8;
    samp[2] = 32'h8080_8080; samp[3] = 32'hF8F8_F8F8;
    launch(1'b1, 3'd2, 32'd5, 0, 0, c0);
    at_cycle(c0 + 14); chk("par_load_c14", {63'd0, load_en_o}, 64'd1);
    at_cycle(c0 + 17); chk("par_events_left", 64'(exp_q.size()), 64'd0);

    // ADC stall of three cycles with stray valid outside REQ
    samp[0] = 32'h1234_5678;
    junk_en = 1'b1;
    launch(1'b0, 3'd1, 32'd7, 3, 0, c0);
    for (int t = 2; t <= 5; t++) begin
      at_cycle(c0 + t);
      any_strb = |strobes();
      chk("stall_req_nostrobe", {62'd0, adc_req_o, any_strb}, 64'd2);
    end
    at_cycle(c0 + 12);
    junk_en = 1'b0;
    chk("stall_events_left", 64'(exp_q.size()), 64'd0);

    // Abort during ACC of slice 2
    samp[0] = 32'h0102_0304; samp[1] = 32'h1112_1314;
    samp[2] = 32'h2122_2324; samp[3] = 32'h3132_3334;
    launch(1'b0, 3'd4, 32'd9, 0, 10, c0);
    at_cycle(c0 + 9);
    abort_i = 1'b1;
    at_cycle(c0 + 10);
    abort_i = 1'b0;
    chk("abort_idle", {62'd0, busy_o, adc_req_o}, 64'd0);
    at_cycle(c0 + 16); chk("abort_events_left", 64'(exp_q.size()), 64'd0);
    samp[0] = 32'hA5A5_5A5A;
    launch(1'b0, 3'd1, 32'd2, 0, 0, c0);
    at_cycle(c0 + 8); chk("post_abort_left", 64'(exp_q.size()), 64'd0);

    // Abort together with start in IDLE
    @(posedge clk_i); #1;
    start_i = 1'b1; abort_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; abort_i = 1'b0;
    chk("abort_beats_start", {63'd0, busy_o}, 64'd0);

    // Slice-count clamping, with a stray start pulse mid-operation
    samp[0] = 32'h0000_00FF;
    launch(1'b0, 3'd0, 32'd1, 0, 0, c0);
    at_cycle(c0 + 8); chk("clamp0_left", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 4; i++) samp[i] = 32'h1000_0000 + 32'(i);
    launch(1'b0, 3'd7, 32'd4, 0, 0, c0);
    at_cycle(c0 + 5);
    start_i = 1'b1;
    at_cycle(c0 + 6);
    start_i = 1'b0;
    at_cycle(c0 + 22); chk("clamp7_left", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset while in RD
    samp[0] = 32'hCAFE_0001; samp[1] = 32'hCAFE_0002;
    launch(1'b0, 3'd2, 32'd6, 0, 4, c0);
    while (cyc != c0 + 4) begin
      @(posedge clk_i);
      #1;
    end
    #1;
    rst_ni = 1'b0;
    #1;
    chk("async_reset_outputs", all_outs(), 64'd0);
    last_out = '0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("after_reset_idle", {63'd0, busy_o}, 64'd0);
    chk("reset_events_left", 64'(exp_q.size()), 64'd0);
    samp[0] = 32'h7777_0000;
    launch(1'b0, 3'd1, 32'd3, 0, 0, c0);
    at_cycle(c0 + 8); chk("post_reset_left", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
